// File: rtl/butterfly_ifu_if.sv
// Bus bundle for the instruction fetch unit: imem request/response, redirect and decode-side handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface butterfly_ifu_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             imem_req_valid_o;
    logic             imem_req_ready_i;
    logic [31:0]      imem_addr_o;
    logic             imem_rsp_valid_i;
    logic [31:0]      imem_rdata_i;
    logic             redirect_valid_i;
    logic [31:0]      redirect_pc_i;
    logic             if_valid_o;
    logic             if_ready_i;
    logic [31:0]      if_instr_o;
    logic [31:0]      if_pc_o;
    logic [CNT_W-1:0] fifo_count_o;

    modport master (
        output imem_req_valid_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, fifo_count_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rdata_i, redirect_valid_i, redirect_pc_i,
               if_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_addr_o, if_valid_o, if_instr_o, if_pc_o, fifo_count_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rdata_i, redirect_valid_i, redirect_pc_i,
               if_ready_i
    );
endinterface

// File: rtl/butterfly_ifu.sv
// Sequential instruction fetch unit: credit-limited imem requests, in-order response buffer,
// and redirect handling that drops responses belonging to the abandoned fetch stream.
module butterfly_ifu #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    butterfly_ifu_if.master bus
);

    localparam int          CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int          PTR_W        = $clog2(FIFO_DEPTH);
    localparam int          OUT_W        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALN = RESET_PC & WORD_MASK;

    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [31:0]      deq_pc_reg, deq_pc_next;
    logic [OUT_W-1:0] outstanding_reg, outstanding_next;
    logic [OUT_W-1:0] discard_reg, discard_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

    logic [31:0]      fifo_mem [FIFO_DEPTH];

    logic             redirect;
    logic [31:0]      redirect_target;
    logic             req_valid;
    logic             accept;
    logic             rsp_take;
    logic             push;
    logic             drop;
    logic             pop;
    logic [OUT_W-1:0] outstanding_after;

    // Event decode
    always_comb begin
        redirect        = bus.redirect_valid_i;
        redirect_target = bus.redirect_pc_i & WORD_MASK;

        // Credit covers both buffered words and words still in flight, so a push always has room.
        req_valid = rst_n_i
                 && (32'(outstanding_reg) < MAX_OUTSTANDING)
                 && ((32'(outstanding_reg) + 32'(count_reg)) < FIFO_DEPTH)
                 && (discard_reg == '0)
                 && !redirect;
        accept    = req_valid && bus.imem_req_ready_i;

        rsp_take  = bus.imem_rsp_valid_i && (outstanding_reg != '0);
        push      = rsp_take && (discard_reg == '0) && !redirect;
        drop      = rsp_take && (discard_reg != '0);
        pop       = (count_reg != '0) && bus.if_ready_i && !redirect;

        outstanding_after = outstanding_reg - (rsp_take ? OUT_W'(1) : OUT_W'(0));
    end

    // Next-state logic
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        deq_pc_next      = deq_pc_reg;
        discard_next     = discard_reg;
        count_next       = count_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        outstanding_next = outstanding_after + (accept ? OUT_W'(1) : OUT_W'(0));

        if (redirect) begin
            fetch_pc_next = redirect_target;
            deq_pc_next   = redirect_target;
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            // Every request still in flight belongs to the old stream, including any already marked.
            discard_next  = outstanding_after;
        end else begin
            if (accept) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
                deq_pc_next = deq_pc_reg + 32'd4;
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
            if (drop) begin
                discard_next = discard_reg - OUT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_reg    <= RESET_PC_ALN;
            deq_pc_reg      <= RESET_PC_ALN;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            deq_pc_reg      <= deq_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    // Instruction storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= bus.imem_rdata_i;
        end
    end

    // Outputs
    always_comb begin
        bus.imem_req_valid_o = req_valid;
        bus.imem_addr_o      = fetch_pc_reg & WORD_MASK;
        bus.if_valid_o       = (count_reg != '0);
        bus.if_instr_o       = fifo_mem[rd_ptr_reg];
        bus.if_pc_o          = deq_pc_reg;
        bus.fifo_count_o     = count_reg;
    end

endmodule
